// File: rtl/freq_meter.sv
// freq_meter
//   Measures a slow, asynchronous square wave against clk. Two independent
//   results are produced:
//     - period : clk cycles between consecutive rising edges of sig_in
//     - freq   : rising edges counted over a gate window selected by SW
//                (with the default gate of CLK_HZ cycles this reads in Hz)
//   A watchdog raises no_signal when no edge is seen for TIMEOUT_CYCLES.
//
// Ports
//   clk          system clock, rising-edge logic only
//   rst_n        asynchronous active-low reset
//   sig_in       signal under measurement (asynchronous to clk)
//   SW[2:0]      gate select: 3'b010 = 1_000, 3'b100 = 100_000,
//                anything else = CLK_HZ cycles
//   period       last measured period in clk cycles
//   period_valid one-cycle pulse when period updates
//   freq         edge count of the last complete gate window
//   freq_valid   one-cycle pulse when freq updates
//   no_signal    high while sig_in is considered absent
//
// Period FSM states
//   state      | meaning
//   WAIT_FIRST | no reference edge yet; next edge only starts a measurement
//   MEASURE    | reference edge seen; next edge reports pcnt as the period

module freq_meter #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
  parameter int unsigned WIDTH          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic [2:0]       SW,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic [WIDTH-1:0] freq,
  output logic             freq_valid,
  output logic             no_signal
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0] GATE_1K   = WIDTH'(1_000);
  localparam logic [WIDTH-1:0] GATE_100K = WIDTH'(100_000);
  localparam logic [WIDTH-1:0] GATE_DEF  = WIDTH'(CLK_HZ);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

  // ------------------------------------------------------------------
  // Input path: synchronizer, one extra register, rising-edge detect
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   sync_out;
  logic                   rise;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    sync_out = sync_q[SYNC_STAGES-1];
    prev_d   = sync_out;
    rise     = sync_out & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // ------------------------------------------------------------------
  // Period path
  // ------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             no_signal_q, no_signal_d;

  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    no_signal_d    = no_signal_q;
    // Saturate at the timeout value so an idle input never wraps the count.
    pcnt_d         = (pcnt_q >= TIMEOUT_W) ? pcnt_q : pcnt_q + ONE;

    case (state_q)
      WAIT_FIRST: begin
        if (rise) begin
          pcnt_d      = ONE;
          state_d     = MEASURE;
          no_signal_d = 1'b0;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d       = pcnt_q;
          period_valid_d = 1'b1;
          pcnt_d         = ONE;
        end
      end
      default: begin
        state_d = WAIT_FIRST;
      end
    endcase

    // An edge coinciding with the timeout wins; the timeout is skipped.
    if (!rise && (pcnt_q >= TIMEOUT_W)) begin
      no_signal_d = 1'b1;
      period_d    = '0;
      state_d     = WAIT_FIRST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= WAIT_FIRST;
      pcnt_q         <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      no_signal_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      no_signal_q    <= no_signal_d;
    end
  end

  // ------------------------------------------------------------------
  // Gate path
  // ------------------------------------------------------------------
  logic [2:0]       sw_q, sw_d;
  logic             sw_seen_q, sw_seen_d;
  logic             sw_change;
  logic [WIDTH-1:0] gate_len;
  logic [WIDTH-1:0] gate_last;
  logic [WIDTH-1:0] gcnt_q, gcnt_d;
  logic [WIDTH-1:0] ecnt_q, ecnt_d;
  logic [WIDTH-1:0] ecnt_sum;
  logic [WIDTH-1:0] freq_q, freq_d;
  logic             freq_valid_q, freq_valid_d;

  always_comb begin
    case (sw_q)
      3'b010:  gate_len = GATE_1K;
      3'b100:  gate_len = GATE_100K;
      default: gate_len = GATE_DEF;
    endcase
    gate_last = gate_len - ONE;
  end

  // The first sample after reset loads the switch without counting as a
  // change, so the first window starts cleanly at gcnt = 0.
  always_comb begin
    sw_d      = SW;
    sw_seen_d = 1'b1;
    sw_change = sw_seen_q && (SW != sw_q);
  end

  always_comb begin
    gcnt_d       = gcnt_q + ONE;
    ecnt_d       = ecnt_q;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
    // An edge in the closing cycle belongs to the closing window.
    ecnt_sum     = (rise && (ecnt_q != CNT_MAX)) ? ecnt_q + ONE : ecnt_q;

    if (sw_change) begin
      gcnt_d = '0;
      ecnt_d = '0;
    end else if (gcnt_q >= gate_last) begin
      freq_d       = ecnt_sum;
      freq_valid_d = 1'b1;
      gcnt_d       = '0;
      ecnt_d       = '0;
    end else begin
      ecnt_d = ecnt_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q         <= 3'b000;
      sw_seen_q    <= 1'b0;
      gcnt_q       <= '0;
      ecnt_q       <= '0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
    end else begin
      sw_q         <= sw_d;
      sw_seen_q    <= sw_seen_d;
      gcnt_q       <= gcnt_d;
      ecnt_q       <= ecnt_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign freq         = freq_q;
  assign freq_valid   = freq_valid_q;
  assign no_signal    = no_signal_q;

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures an external slow square wave (`sig_in`) against the system clock. It is the measuring counterpart of the team's switch-selected clock divider.
- Reports two results:
  - the period of `sig_in`, in `clk` cycles, between consecutive rising edges;
  - the rising-edge count over a switch-selected gate window, i.e. the frequency in Hz when the default 1 s gate is selected.
- Intended use: self-checking a divider's `clk_N` output on the board, and driving seven-segment display logic.

Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency; the default gate length in cycles.
- `SYNC_STAGES`, 2: number of flip-flops in the `sig_in` synchronizer; minimum 2.
- `TIMEOUT_CYCLES`, 200_000_000: number of cycles without an edge before `no_signal` is asserted.
- `WIDTH`, 32: width of all counters and result buses.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge triggered.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sig_in`  in  1  signal under measurement; asynchronous to `clk`.
- `SW`  in  3  gate select: 3'b010 = 1_000 cycles; 3'b100 = 100_000 cycles; any other value = `CLK_HZ` cycles.
- `period`  out  `WIDTH`  last measured period, in `clk` cycles.
- `period_valid`  out  1  one-cycle pulse when `period` updates.
- `freq`  out  `WIDTH`  rising edges counted in the last complete gate window.
- `freq_valid`  out  1  one-cycle pulse when `freq` updates.
- `no_signal`  out  1  level; high while `sig_in` is considered absent.

Behaviour:
- Reset (async assert, sync release): all outputs are 0; all counters are 0; state = WAIT_FIRST; the synchronizer is cleared to 0.
- Input path:
  - `sig_in` passes through the `SYNC_STAGES` synchronizer, then one extra register.
  - `edge` = sync_out & ~prev.
  - A rising edge sampled at `clk` edge k produces `edge` high in cycle k+`SYNC_STAGES`. It is one cycle wide per rising edge.
- Period FSM, states WAIT_FIRST and MEASURE. `pcnt` is a `WIDTH`-bit counter that increments every cycle.
  - WAIT_FIRST on `edge`:
    - `pcnt` <= 1;
    - go to MEASURE;
    - `no_signal` <= 0;
    - no `period_valid`.
  - MEASURE on `edge`:
    - `period` <= `pcnt`;
    - `period_valid` <= 1 for one cycle;
    - `pcnt` <= 1.
  - Result: edges at cycles t0 and t0+P give `period` = P, with `period_valid` in cycle t0+P+1.
  - Timeout: when `pcnt` reaches `TIMEOUT_CYCLES` with no `edge` in either state:
    - `no_signal` <= 1;
    - `period` <= 0;
    - go to WAIT_FIRST;
    - `pcnt` holds at `TIMEOUT_CYCLES`, so it never wraps.
  - `edge` in the same cycle as the timeout: the edge takes priority and the timeout is not taken.
- Gate path:
  - G is the value decoded from `SW`.
  - `gcnt` counts 0..G-1 and wraps. `ecnt` counts edges.
  - In the cycle `gcnt` == G-1:
    - `freq` <= `ecnt` + `edge`, so an edge in the last cycle belongs to the closing window;
    - `freq_valid` <= 1 for one cycle;
    - `ecnt` <= 0;
    - `gcnt` <= 0.
  - `SW` is registered once. If the registered value changes, the gate restarts:
    - `gcnt` <= 0 and `ecnt` <= 0;
    - the partial window is discarded with no `freq_valid`;
    - `freq` holds its old value.
  - `freq` and `ecnt` never wrap. An implementation may assume fewer than 2^`WIDTH` edges per window.
- The period path and gate path run independently. Both may pulse their valid outputs in the same cycle.
- `rst_n` low mid-window or mid-period aborts immediately. The first window after release starts at `gcnt` = 0.

Test Plan:
- Reset, then `sig_in` = 0, `SW` = 010 for 2_500 cycles → exactly 2 `freq_valid` pulses, at cycles 1_000 and 2_000 after release; `freq` = 0; `period_valid` never asserted.
- `sig_in` toggles every 50 cycles (period 100) → first edge gives no pulse; each later edge gives `period` = 100 with `period_valid`. With `SW` = 010, steady-state `freq` = 10.
- Edge placed on the last gate cycle (`gcnt` = 999) → that edge is counted in the closing window's `freq`, not the next one.
- `SW` changed 010→100 mid-window → no `freq_valid` for that window; next `freq_valid` comes 100_000 cycles after the change.
- `TIMEOUT_CYCLES` overridden to 500, `sig_in` stops → `no_signal` = 1 and `period` = 0 at 500 cycles after the last edge. On resumption, the first edge clears `no_signal` without `period_valid`; the second edge reports the correct period.
- `rst_n` pulsed low asynchronously mid-measurement → all outputs are 0 immediately, before the next `clk` edge; after release the first edge gives no `period_valid`.
